// File: rtl/mem_cmd_master_if.sv
// rtl/mem_cmd_master_if.sv - host command/response and memory request signal bundle
interface mem_cmd_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int WIDTH      = 16
);
  // host command port
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_wr_rd_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [WIDTH-1:0]      cmd_wdata_i;
  // host response port
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_wr_o;
  logic [WIDTH-1:0]      rsp_rdata_o;
  logic                  rsp_err_o;
  // memory request port
  logic                  mem_valid_o;
  logic                  mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic                  mem_ready_i;
  logic [WIDTH-1:0]      mem_rdata_i;
  // status
  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_wr_rd_i, cmd_addr_i, cmd_wdata_i,
    input  rsp_ready_i, mem_ready_i, mem_rdata_i,
    output cmd_ready_o, rsp_valid_o, rsp_wr_o, rsp_rdata_o, rsp_err_o,
    output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_wr_rd_i, cmd_addr_i, cmd_wdata_i,
    output rsp_ready_i, mem_ready_i, mem_rdata_i,
    input  cmd_ready_o, rsp_valid_o, rsp_wr_o, rsp_rdata_o, rsp_err_o,
    input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/mem_cmd_master.sv
// rtl/mem_cmd_master.sv - buffered single-outstanding request master for the single-port memory
module mem_cmd_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_cmd_master_if.master  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_WIDTH + WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_inc;
  logic             timeout_hit;
  logic             cap_ok;
  logic             cap_err;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even when the FSM pops in the same cycle.
  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  assign bus.cmd_ready_o = !fifo_full;
  assign push        = bus.cmd_valid_i && !fifo_full;

  assign timer_inc   = timer + TMR_W'(1);
  assign timeout_hit = (timer_inc == TMR_W'(TIMEOUT));

  assign bus.mem_valid_o = (state == S_ISSUE);
  assign bus.rsp_valid_o = (state == S_RESP);
  assign bus.busy_o      = !fifo_empty || (state != S_IDLE);

  // Command storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.cmd_wr_rd_i, bus.cmd_addr_i, bus.cmd_wdata_i};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transaction state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle control strobes; a ready in the last WAIT cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_ok    = 1'b0;
    cap_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_ready_i) begin
          cap_ok    = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout_hit) begin
          cap_err   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory request fields load on pop and hold until the next pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.mem_wr_rd_o <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else if (pop) begin
      {bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o} <= fifo_mem[rd_ptr];
    end
  end

  // WAIT-cycle timer: cleared while issuing, saturates at TIMEOUT so it never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer <= '0;
    end else if (state == S_ISSUE) begin
      timer <= '0;
    end else if (state == S_WAIT && timer != TMR_W'(TIMEOUT)) begin
      timer <= timer_inc;
    end
  end

  // Response fields capture once on leaving WAIT and stay put through RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rsp_wr_o    <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
    end else if (cap_ok) begin
      bus.rsp_wr_o    <= bus.mem_wr_rd_o;
      bus.rsp_rdata_o <= bus.mem_wr_rd_o ? '0 : bus.mem_rdata_i;
      bus.rsp_err_o   <= 1'b0;
    end else if (cap_err) begin
      bus.rsp_wr_o    <= bus.mem_wr_rd_o;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_cmd_master.sv
// tb/tb_mem_cmd_master.sv - randomized self-checking bench for mem_cmd_master
module tb_mem_cmd_master;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_cmd_master_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

  mem_cmd_master #(
    .ADDR_WIDTH(AW), .WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // expected response: {wr, err, rdata}
  logic [17:0]   exp_q[$];
  logic [DW-1:0] model_mem [64];
  bit            dead    = 1'b0;
  int            max_lat = 0;
  int            rdy_mode = 1;

  int            push_cyc    = 0;
  int            n_pushed    = 0;
  int            n_disc      = 0;
  int            last_mv_cyc = 0;
  int            mv_pulses   = 0;
  int            last_rsp_cyc = 0;
  int            n_rsp       = 0;
  logic          last_mv_wr  = 1'b0;
  logic [AW-1:0] last_mv_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // host response-ready driver: 0 low, 1 high, 2 random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.rsp_ready_i = 1'b0;
      1:       bus.rsp_ready_i = 1'b1;
      default: bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
    endcase
  end

  // memory environment: performs the access on the valid pulse, answers after a random delay
  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    int            lat;
    logic [DW-1:0] tb_mem [64];
    for (int i = 0; i < 64; i++) tb_mem[i] = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_valid_o && !dead) begin
        a = bus.mem_addr_o;
        if (bus.mem_wr_rd_o) begin
          tb_mem[a] = bus.mem_wdata_o;
          rd = DW'($urandom);
        end else begin
          rd = tb_mem[a];
        end
        lat = $urandom_range(0, max_lat);
        @(posedge clk);
        repeat (lat) @(posedge clk);
        #1;
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = rd;
        @(posedge clk);
        #1;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = DW'($urandom);
      end
    end
  end

  // output monitor: single-cycle valid pulses, response stability and in-order scoreboard
  logic        prev_mv = 1'b0;
  logic        prev_rv = 1'b0;
  logic [17:0] prev_rsp = '0;
  always @(negedge clk) begin
    logic [17:0] cur;
    logic [17:0] e;
    if (rst) begin
      prev_mv = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (bus.mem_valid_o) begin
        check("mem_valid_single", prev_mv, 0);
        if (!prev_mv) begin
          mv_pulses++;
          last_mv_cyc  = cyc;
          last_mv_wr   = bus.mem_wr_rd_o;
          last_mv_addr = bus.mem_addr_o;
        end
      end
      prev_mv = bus.mem_valid_o;
      cur = {bus.rsp_wr_o, bus.rsp_err_o, bus.rsp_rdata_o};
      if (bus.rsp_valid_o) begin
        if (!prev_rv) last_rsp_cyc = cyc;
        else          check("rsp_stable", cur, prev_rsp);
        if (bus.rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("rsp", cur, e);
          end
          n_rsp++;
          prev_rv = 1'b0;
        end else begin
          prev_rv = 1'b1;
        end
      end else begin
        prev_rv = 1'b0;
      end
      prev_rsp = cur;
    end
  end

  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_wr_rd_i = wr;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (i > 0) @(negedge clk);
      acc = bus.cmd_ready_o;
      if (acc) push_cyc = cyc + 1;
      @(posedge clk);
    end
    if (acc) begin
      n_pushed++;
      if (dead) begin
        exp_q.push_back({wr, 1'b1, 16'h0000});
      end else if (wr) begin
        model_mem[a] = d;
        exp_q.push_back({1'b1, 1'b0, 16'h0000});
      end else begin
        exp_q.push_back({1'b0, 1'b0, model_mem[a]});
      end
    end else begin
      check("push_timeout", acc, 1);
    end
  endtask

  task automatic idle_cmd();
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check({tag, "_idle"}, bus.busy_o, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
    check({tag, "_flags"}, {bus.rsp_valid_o, bus.rsp_wr_o, bus.rsp_err_o,
                            bus.mem_valid_o, bus.mem_wr_rd_o, bus.busy_o}, 0);
    check({tag, "_rdata"}, bus.rsp_rdata_o, 0);
    check({tag, "_mem_bus"}, {bus.mem_addr_o, bus.mem_wdata_o}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int saved;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wr_rd_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;

    // reset values
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // single write: pulse timing and response latency
    rdy_mode = 1;
    max_lat  = 0;
    push_cmd(1'b1, 6'h03, 16'hA5A5);
    idle_cmd();
    wait_drain("t1_drain");
    check("t1_mv_cyc", last_mv_cyc, push_cyc + 1);
    check("t1_rsp_cyc", last_rsp_cyc, push_cyc + 3);
    check("t1_pulses", mv_pulses, 1);
    check("t1_mem_wr", last_mv_wr, 1);
    check("t1_mem_addr", last_mv_addr, 3);
    check("t1_wdata_hold", bus.mem_wdata_o, 16'hA5A5);

    // write then read back the same location
    push_cmd(1'b1, 6'h10, 16'h1234);
    push_cmd(1'b0, 6'h10, 16'h0000);
    idle_cmd();
    wait_drain("t2_drain");
    check("t2_rsp_count", n_rsp, 3);

    // fill with responses blocked, then push against a full FIFO while it pops
    max_lat  = 3;
    rdy_mode = 0;
    for (int i = 0; i < 5; i++)
      push_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
    @(negedge clk);
    check("t3_full_ready", bus.cmd_ready_o, 0);
    check("t3_busy", bus.busy_o, 1);
    fork
      push_cmd(1'b0, 6'h10, 16'h0000);
      begin
        repeat (6) @(negedge clk);
        check("t3_ready_low", bus.cmd_ready_o, 0);
        check("t3_rsp_held", bus.rsp_valid_o, 1);
        rdy_mode = 1;
      end
    join
    check("t6_push_after_pop", push_cyc, last_mv_cyc + 1);
    idle_cmd();
    wait_drain("t3_drain");

    // memory never answers: timeout error, then normal traffic
    dead = 1'b1;
    push_cmd(1'b0, 6'h10, 16'h0000);
    idle_cmd();
    wait_drain("t4_drain");
    check("t4_err_lat", last_rsp_cyc, push_cyc + 2 + TO);
    dead = 1'b0;
    push_cmd(1'b1, 6'h21, 16'hBEEF);
    push_cmd(1'b0, 6'h21, 16'h0000);
    idle_cmd();
    wait_drain("t4_recover");

    // reset while waiting with two commands queued
    dead = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, AW'(i), 16'h0000);
    idle_cmd();
    repeat (4) @(negedge clk);
    check("t5_pre_busy", bus.busy_o, 1);
    rst = 1'b1;
    exp_q.delete();
    n_disc += 3;
    saved = n_rsp;
    @(negedge clk);
    check_reset("t5");
    rst  = 1'b0;
    dead = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_no_rsp", n_rsp, saved);
    check("t5_busy", bus.busy_o, 0);
    push_cmd(1'b1, 6'h05, 16'h0F0F);
    push_cmd(1'b0, 6'h05, 16'h0000);
    idle_cmd();
    wait_drain("t5_recover");

    // random traffic with random response back-pressure, wraps the pointers many times
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        idle_cmd();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    idle_cmd();
    wait_drain("rand_drain");
    check("rsp_total", n_rsp, n_pushed - n_disc);
    check("pulse_total", mv_pulses, n_rsp + 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
